// File: rtl/prog_calc_pkg.sv
// prog_calc_pkg: shared opcode and controller-state types for the
// programmable calculator and its ALU.
package prog_calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_MAC = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/prog_calculator_alu.sv
// calc_alu: purely combinational arithmetic for one instruction.
// SUB reports the magnitude of A-B with a separate sign flag; MAC adds the
// full-width product to the running accumulator, wrapping at 2*DATA_W bits.
module calc_alu
    import prog_calc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  op_e                 op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [2*DATA_W-1:0] acc,
    output logic [2*DATA_W-1:0] value,
    output logic                neg
);

    localparam int RES_W = 2 * DATA_W;

    logic [RES_W-1:0] a_ext;
    logic [RES_W-1:0] b_ext;
    logic [RES_W-1:0] product;

    assign a_ext   = RES_W'(a);
    assign b_ext   = RES_W'(b);
    assign product = a_ext * b_ext;

    // Select the operation result and sign flag for the current opcode.
    always_comb begin
        value = '0;
        neg   = 1'b0;
        case (op)
            OP_ADD: value = a_ext + b_ext;
            OP_SUB: begin
                if (a < b) begin
                    value = b_ext - a_ext;
                    neg   = 1'b1;
                end else begin
                    value = a_ext - b_ext;
                end
            end
            OP_MUL: value = product;
            OP_MAC: value = acc + product;
            default: value = '0;
        endcase
    end

endmodule

// File: rtl/prog_calculator.sv
// prog_calculator: collects up to DEPTH {op,A,B} instruction words, then
// executes them in order, one per cycle, through calc_alu. Each result shows
// up one cycle after its issue; a one-cycle done pulse follows the last one.
// Optional feature: define PROG_CALCULATOR_LOOP_EN to add a 'loop' input that
// re-runs the loaded program (accumulator cleared) instead of returning to LOAD.
module prog_calculator
    import prog_calc_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int DEPTH   = 16,
    localparam int INSTR_W = 2 + 2 * DATA_W,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
`ifdef PROG_CALCULATOR_LOOP_EN
    input  logic                 loop,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_W-1:0]   din,
    input  logic                 start,
    output logic                 busy,
    output logic                 res_valid,
    output logic [2*DATA_W-1:0]  result,
    output logic                 neg,
    output logic                 done,
    output logic [CNT_W-1:0]     count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int RES_W  = 2 * DATA_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_e             state;
    state_e             state_next;
    logic [INSTR_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]   ptr;
    logic [CNT_W-1:0]   count_inc;
    logic [RES_W-1:0]   acc;
    logic [RES_W-1:0]   alu_value;
    logic               alu_neg;
    logic               wr_en;
    logic               issue;
    logic               enter_run;
    logic [INSTR_W-1:0] instr;
    op_e                instr_op;
    logic [DATA_W-1:0]  instr_a;
    logic [DATA_W-1:0]  instr_b;

    // A word is only taken while loading and there is room; the count that
    // includes it decides whether this cycle also launches the run.
    assign wr_en     = in_valid && in_ready;
    assign count_inc = count + CNT_W'(wr_en);

    // ptr == count is a drain cycle: nothing issues, the last result is shown.
    assign issue     = (state == ST_RUN) && (ptr < count);
    assign enter_run = (state != ST_RUN) && (state_next == ST_RUN);

    assign instr    = mem[ptr[ADDR_W-1:0]];
    assign instr_op = op_e'(instr[INSTR_W-1 -: 2]);
    assign instr_a  = instr[2*DATA_W-1 -: DATA_W];
    assign instr_b  = instr[DATA_W-1:0];

    calc_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .op   (instr_op),
        .a    (instr_a),
        .b    (instr_b),
        .acc  (acc),
        .value(alu_value),
        .neg  (alu_neg)
    );

    // Program memory is deliberately left unreset; only loaded entries are read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count[ADDR_W-1:0]] <= din;
        end
    end

    // Next-state selection plus the state-decoded handshake/status outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_LOAD: begin
                in_ready = (count < DEPTH_C);
                if ((count_inc == DEPTH_C) || (start && (count_inc != '0))) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (ptr == count) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
`ifdef PROG_CALCULATOR_LOOP_EN
                state_next = loop ? ST_RUN : ST_LOAD;
`else
                state_next = ST_LOAD;
`endif
            end
            default: state_next = ST_LOAD;
        endcase
    end

    // State, counters, accumulator and the registered result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_LOAD;
            count     <= '0;
            ptr       <= '0;
            acc       <= '0;
            result    <= '0;
            neg       <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            state     <= state_next;
            res_valid <= issue;
            if (wr_en) begin
                count <= count_inc;
            end else if ((state == ST_DONE) && (state_next == ST_LOAD)) begin
                count <= '0;
            end
            if (enter_run) begin
                ptr <= '0;
                acc <= '0;
            end else if (issue) begin
                ptr <= ptr + CNT_W'(1);
                if (instr_op == OP_MAC) begin
                    acc <= alu_value;
                end
            end
            if (issue) begin
                result <= alu_value;
                neg    <= alu_neg;
            end
        end
    end

endmodule

// File: tb/tb_prog_calculator.sv
// tb_prog_calculator: directed and randomized programs for prog_calculator,
// checked against an arithmetic reference model of the instruction set.
module tb_prog_calculator;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int IW    = 2 + 2 * DW;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int RW    = 2 * DW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] din;
    logic          start;
    logic          busy;
    logic          res_valid;
    logic [RW-1:0] result;
    logic          neg;
    logic          done;
    logic [CW-1:0] count;
`ifdef PROG_CALCULATOR_LOOP_EN
    logic          loop;
`endif

    int     checks = 0;
    int     errors = 0;
    int     prog_op [DEPTH];
    int     prog_a  [DEPTH];
    int     prog_b  [DEPTH];
    longint exp_res [DEPTH];
    bit     exp_neg [DEPTH];

    prog_calculator #(
        .DATA_W(DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
`ifdef PROG_CALCULATOR_LOOP_EN
        .loop     (loop),
`endif
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din      (din),
        .start    (start),
        .busy     (busy),
        .res_valid(res_valid),
        .result   (result),
        .neg      (neg),
        .done     (done),
        .count    (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic apply_stimulus(input bit v, input logic [IW-1:0] d, input bit s);
        in_valid = v;
        din      = d;
        start    = s;
    endtask

    task automatic set_instr(input int i, input int op, input int a, input int b);
        prog_op[i] = op;
        prog_a[i]  = a;
        prog_b[i]  = b;
    endtask

    function automatic logic [IW-1:0] word(input int i);
        return {prog_op[i][1:0], prog_a[i][DW-1:0], prog_b[i][DW-1:0]};
    endfunction

    function automatic int rnd_operand();
        case ($urandom_range(7))
            0:       return 0;
            1:       return (1 << DW) - 1;
            default: return int'($urandom_range((1 << DW) - 1));
        endcase
    endfunction

    // Reference: plain integer arithmetic per opcode, accumulator from zero.
    function automatic void model(input int n);
        longint acc  = 0;
        longint mask = (longint'(1) << RW) - 1;
        for (int i = 0; i < n; i++) begin
            longint a = prog_a[i];
            longint b = prog_b[i];
            exp_neg[i] = 1'b0;
            case (prog_op[i])
                0: exp_res[i] = a + b;
                1: begin
                    exp_res[i] = (a >= b) ? a - b : b - a;
                    exp_neg[i] = (a < b);
                end
                2: exp_res[i] = a * b;
                default: begin
                    acc        = (acc + a * b) & mask;
                    exp_res[i] = acc;
                end
            endcase
        end
    endfunction

    // Load n words (random idle gaps), launch, and check the whole run.
    task automatic run_program(input int n, input bit start_with_last);
        model(n);
        check_output("load_idle_count", 64'(count), 64'(0));
        check_output("load_idle_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(3) == 0) begin
                apply_stimulus(1'b0, IW'($urandom), 1'b0);
                tick();
                check_output("gap_count", 64'(count), 64'(i));
            end
            check_output("load_ready", 64'(in_ready), 64'(1));
            apply_stimulus(1'b1, word(i), (i == n - 1) && start_with_last && (n < DEPTH));
            tick();
            if (i < n - 1) begin
                check_output("load_count", 64'(count), 64'(i + 1));
                check_output("load_busy", 64'(busy), 64'(0));
            end
        end
        if ((n < DEPTH) && !start_with_last) begin
            apply_stimulus(1'b0, IW'($urandom), 1'b1);
            tick();
        end
        check_output("run_entry_busy", 64'(busy), 64'(1));
        check_output("run_entry_rvalid", 64'(res_valid), 64'(0));
        check_output("run_entry_ready", 64'(in_ready), 64'(0));
        check_output("run_entry_count", 64'(count), 64'(n));
        for (int c = 1; c <= n + 1; c++) begin
            apply_stimulus(1'($urandom_range(1)), IW'($urandom), 1'($urandom_range(1)));
            tick();
            check_output("run_count", 64'(count), 64'(n));
            if (c <= n) begin
                check_output("run_rvalid", 64'(res_valid), 64'(1));
                check_output("run_result", 64'(result), 64'(exp_res[c-1]));
                check_output("run_neg", 64'(neg), 64'(exp_neg[c-1]));
                check_output("run_done", 64'(done), 64'(0));
            end else begin
                check_output("done_pulse", 64'(done), 64'(1));
                check_output("done_rvalid", 64'(res_valid), 64'(0));
                check_output("done_busy", 64'(busy), 64'(0));
                check_output("done_ready", 64'(in_ready), 64'(0));
            end
        end
        apply_stimulus(1'b1, IW'($urandom), 1'($urandom_range(1)));
        tick();
        check_output("back_count", 64'(count), 64'(0));
        check_output("back_ready", 64'(in_ready), 64'(1));
        check_output("back_done", 64'(done), 64'(0));
        check_output("back_busy", 64'(busy), 64'(0));
        check_output("hold_result", 64'(result), 64'(exp_res[n-1]));
        check_output("hold_neg", 64'(neg), 64'(exp_neg[n-1]));
        apply_stimulus(1'b0, '0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        apply_stimulus(1'b0, '0, 1'b0);
`ifdef PROG_CALCULATOR_LOOP_EN
        loop = 1'b0;
`endif
        repeat (3) tick();
        check_output("rst_result", 64'(result), 64'(0));
        check_output("rst_rvalid", 64'(res_valid), 64'(0));
        check_output("rst_done", 64'(done), 64'(0));
        check_output("rst_busy", 64'(busy), 64'(0));
        check_output("rst_count", 64'(count), 64'(0));
        reset_n = 1'b1;
        tick();
        check_output("rst_ready", 64'(in_ready), 64'(1));

        $display("[TB] start with empty program");
        apply_stimulus(1'b0, IW'($urandom), 1'b1);
        tick();
        check_output("empty_start_busy", 64'(busy), 64'(0));
        check_output("empty_start_count", 64'(count), 64'(0));
        apply_stimulus(1'b0, '0, 1'b0);
        tick();
        check_output("empty_start_ready", 64'(in_ready), 64'(1));

        $display("[TB] full program of ADD 3,4 with automatic run");
        for (int i = 0; i < DEPTH; i++) set_instr(i, 0, 3, 4);
        run_program(DEPTH, 1'b0);

        $display("[TB] SUB sign handling");
        set_instr(0, 1, 5, 9);
        set_instr(1, 1, 9, 5);
        set_instr(2, 1, 7, 7);
        run_program(3, 1'b1);

        $display("[TB] MUL and MAC wrap");
        set_instr(0, 2, 255, 255);
        set_instr(1, 3, 255, 255);
        set_instr(2, 3, 255, 255);
        run_program(3, 1'b1);

        $display("[TB] random programs");
        for (int t = 0; t < 20; t++) begin
            int n;
            n = (t % 5 == 0) ? DEPTH : int'($urandom_range(DEPTH, 1));
            for (int i = 0; i < n; i++) begin
                set_instr(i, int'($urandom_range(3)), rnd_operand(), rnd_operand());
            end
            run_program(n, 1'($urandom_range(1)));
        end

        $display("[TB] reset in the middle of a run");
        for (int i = 0; i < 8; i++) begin
            set_instr(i, int'($urandom_range(3)), rnd_operand(), rnd_operand());
            apply_stimulus(1'b1, word(i), i == 7);
            tick();
        end
        apply_stimulus(1'b0, '0, 1'b0);
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        check_output("abort_result", 64'(result), 64'(0));
        check_output("abort_neg", 64'(neg), 64'(0));
        check_output("abort_rvalid", 64'(res_valid), 64'(0));
        check_output("abort_done", 64'(done), 64'(0));
        check_output("abort_busy", 64'(busy), 64'(0));
        check_output("abort_count", 64'(count), 64'(0));
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_output("abort_no_done", 64'(done), 64'(0));
        end
        set_instr(0, 0, 1, 1);
        run_program(1, 1'b1);

`ifdef PROG_CALCULATOR_LOOP_EN
        $display("[TB] looping MAC program");
        loop = 1'b1;
        set_instr(0, 3, 2, 3);
        set_instr(1, 3, 2, 3);
        apply_stimulus(1'b1, word(0), 1'b0);
        tick();
        apply_stimulus(1'b1, word(1), 1'b1);
        tick();
        apply_stimulus(1'b0, '0, 1'b0);
        check_output("loop_entry_busy", 64'(busy), 64'(1));
        for (int p = 0; p < 3; p++) begin
            tick();
            check_output("loop_res0", 64'(result), 64'(6));
            check_output("loop_rv0", 64'(res_valid), 64'(1));
            tick();
            check_output("loop_res1", 64'(result), 64'(12));
            tick();
            check_output("loop_done", 64'(done), 64'(1));
            if (p == 2) loop = 1'b0;
            tick();
            if (p < 2) begin
                check_output("loop_rerun_busy", 64'(busy), 64'(1));
                check_output("loop_rerun_count", 64'(count), 64'(2));
            end else begin
                check_output("loop_exit_ready", 64'(in_ready), 64'(1));
                check_output("loop_exit_count", 64'(count), 64'(0));
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_calculator.md
PROG_CALCULATOR -- requirements
Module: prog_calculator

Interface
REQ-001 Parameter DATA_W, default 8, operand width in bits (legal 4..16).
REQ-002 Parameter DEPTH, default 16, program memory depth in instructions (power of two, 2..64).
REQ-003 Derived constant INSTR_W = 2 + 2*DATA_W; instruction = {op[1:0], A[DATA_W-1:0], B[DATA_W-1:0]}.
REQ-004 clk  input  1  rising-edge clock; the block SHALL use this single clock only.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 in_valid  input  1  din holds an instruction to load.
REQ-007 in_ready  output  1  block accepts din this cycle.
REQ-008 din  input  INSTR_W  instruction word.
REQ-009 start  input  1  request execution of the loaded program.
REQ-010 busy  output  1  high in RUN.
REQ-011 res_valid  output  1  result/neg carry a fresh value this cycle.
REQ-012 result  output  2*DATA_W  last computed value.
REQ-013 neg  output  1  last SUB result was negative.
REQ-014 done  output  1  one-cycle pulse, program finished.
REQ-015 count  output  clog2(DEPTH)+1  number of instructions loaded.

Function
REQ-016 FSM states LOAD, RUN, DONE; the block SHALL leave reset in LOAD.
REQ-017 LOAD: in_ready = (count < DEPTH); on in_valid && in_ready, din SHALL be written at index count and count incremented.
REQ-018 LOAD->RUN when count reaches DEPTH (automatic), or on start with count >= 1; start with count == 0 SHALL be ignored.
REQ-019 Word accepted in the same cycle as start SHALL be included in the run.
REQ-020 in_valid while in_ready = 0 (full, RUN, DONE) SHALL be dropped without side effect.
REQ-021 RUN: one instruction per cycle in index order 0..count-1; result/neg registered; res_valid high on the cycle after each issue, i.e. count consecutive res_valid cycles starting one cycle after RUN entry.
REQ-022 op 00 ADD: result = A + B, neg = 0.
REQ-023 op 01 SUB: result = |A - B| zero-extended, neg = (A < B); A == B gives 0, neg = 0.
REQ-024 op 10 MUL: result = A * B (full 2*DATA_W), neg = 0.
REQ-025 op 11 MAC: acc = acc + A*B modulo 2^(2*DATA_W), result = new acc, neg = 0; acc SHALL be cleared on every RUN entry.
REQ-026 After the last issue: DONE for exactly one cycle with done = 1 (cycle after the final res_valid); then LOAD with count = 0.
REQ-027 result and neg SHALL hold their last values outside res_valid cycles, including across DONE->LOAD.
REQ-028 start in RUN or DONE SHALL be ignored.

Reset
REQ-029 On reset_n low, immediately: state LOAD, count 0, pointers 0, acc 0, result 0, neg 0, res_valid 0, done 0, busy 0; in_ready 1 after release.
REQ-030 Reset mid-RUN SHALL abort without a done pulse; memory contents are not reset and SHALL NOT be relied upon.

Configuration
REQ-031 Macro PROG_CALCULATOR_LOOP_EN: when defined, input port loop (1 bit) exists; in DONE with loop = 1 the FSM SHALL re-enter RUN with count retained (acc cleared) instead of returning to LOAD; done still pulses each pass.
REQ-032 Without PROG_CALCULATOR_LOOP_EN the loop port SHALL be absent and DONE always returns to LOAD.

Structure
REQ-033 Package prog_calc_pkg SHALL hold the opcode enum (OP_ADD, OP_SUB, OP_MUL, OP_MAC) and the state enum.
REQ-034 Combinational sub-module calc_alu (parametrised by DATA_W: op, a, b, acc -> value, neg) SHALL implement REQ-022..025; FSM, memory and registers stay in prog_calculator.

Verification
REQ-035 DATA_W=8, DEPTH=16: load 16 words ADD 3,4 -> auto RUN, 16 res_valid cycles each result 7, then done pulse, count 0.
REQ-036 Load 3 words {SUB 5,9; SUB 9,5; SUB 7,7} + start -> results 4/neg1, 4/neg0, 0/neg0, done on 4th cycle after last issue window.
REQ-037 MUL 255,255 -> 65025; MAC 255,255 twice -> 65025, then 64514 (wrap).
REQ-038 Fill to 16, drive in_valid in RUN -> in_ready 0, no write, program unchanged; start with count 0 -> stays LOAD.
REQ-039 Assert reset_n low mid-RUN -> all outputs 0 asynchronously, no done; reload 1 word ADD 1,1 + start -> result 2.
REQ-040 With PROG_CALCULATOR_LOOP_EN, loop=1, program MAC 2,3 x2 -> results 6,12 each pass, done each pass, never returns to LOAD.
